// File: rtl/uart_cmd_controller.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_controller
// Purpose  : Parses 4-byte command frames (SYNC, CMD, ARG, CHK) arriving as
//            one-cycle byte strobes from uart_rx. Validated commands update the
//            LED pattern/mode registers; bad or timed-out frames are flagged
//            and counted instead.
// Ports    : i_clk, i_rst_n (async active-low)
//            i_ready_rx / i_data_rx  - received byte strobe and data
//            o_enb_rx                - receiver enable (low only in EXEC)
//            o_led_data / o_led_we   - LED pattern register and update pulse
//            o_mode                  - display mode register
//            o_busy                  - frame partially received
//            o_frame_err / o_err_cnt - error pulse and saturating error count
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_controller #(
  parameter int                   DATA_BITS      = 8,
  parameter logic [DATA_BITS-1:0] SYNC_BYTE      = 8'hA5,
  parameter int                   TIMEOUT_CYCLES = 500_000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_ready_rx,
  input  logic [DATA_BITS-1:0] i_data_rx,
  output logic                 o_enb_rx,
  output logic [DATA_BITS-1:0] o_led_data,
  output logic                 o_led_we,
  output logic [1:0]           o_mode,
  output logic                 o_busy,
  output logic                 o_frame_err,
  output logic [7:0]           o_err_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  // Elaboration-time parameter guards.
  if (DATA_BITS != 8) begin : g_bad_data_bits
    $error("uart_cmd_controller: DATA_BITS must be 8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_cmd_controller: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_CMD = 3'd1,
    S_WAIT_ARG = 3'd2,
    S_WAIT_CHK = 3'd3,
    S_EXEC     = 3'd4
  } state_t;

  state_t               state, state_next;
  logic [DATA_BITS-1:0] cmd, arg;
  logic [CNT_W-1:0]     cnt;
  logic                 in_wait, timeout, cmd_known, frame_ok;
  logic                 err_now, latch_cmd, latch_arg;

  assign in_wait  = (state == S_WAIT_CMD) || (state == S_WAIT_ARG) || (state == S_WAIT_CHK);
  // A strobe in the same cycle takes priority over the timeout.
  assign timeout  = in_wait && !i_ready_rx && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign o_busy   = in_wait;
  assign o_enb_rx = (state != S_EXEC);

  // Mode argument must fit in two bits; anything else is a bad frame.
  always_comb begin
    cmd_known = 1'b0;
    case (cmd)
      8'h01, 8'h03, 8'h04: cmd_known = 1'b1;
      8'h02:               cmd_known = (arg[DATA_BITS-1:2] == '0);
      default:             cmd_known = 1'b0;
    endcase
  end

  assign frame_ok = (i_data_rx == (SYNC_BYTE ^ cmd ^ arg)) && cmd_known;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    err_now    = 1'b0;
    latch_cmd  = 1'b0;
    latch_arg  = 1'b0;
    case (state)
      S_IDLE: begin
        // Non-sync bytes outside a frame are dropped silently.
        if (i_ready_rx && (i_data_rx == SYNC_BYTE)) state_next = S_WAIT_CMD;
      end
      S_WAIT_CMD: begin
        if (i_ready_rx) begin
          latch_cmd  = 1'b1;
          state_next = S_WAIT_ARG;
        end else if (timeout) begin
          err_now    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WAIT_ARG: begin
        if (i_ready_rx) begin
          latch_arg  = 1'b1;
          state_next = S_WAIT_CHK;
        end else if (timeout) begin
          err_now    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WAIT_CHK: begin
        if (i_ready_rx) begin
          if (frame_ok) begin
            state_next = S_EXEC;
          end else begin
            err_now    = 1'b1;
            state_next = S_IDLE;
          end
        end else if (timeout) begin
          err_now    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_EXEC:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Inter-byte counter: held at zero outside a frame and on every strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (!in_wait || i_ready_rx) begin
      cnt <= '0;
    end else if (!timeout) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cmd         <= '0;
      arg         <= '0;
      o_led_data  <= '0;
      o_led_we    <= 1'b0;
      o_mode      <= 2'd0;
      o_frame_err <= 1'b0;
      o_err_cnt   <= 8'd0;
    end else begin
      o_led_we    <= 1'b0;
      o_frame_err <= err_now;
      if (latch_cmd) cmd <= i_data_rx;
      if (latch_arg) arg <= i_data_rx;
      if (err_now && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 8'd1;
      if (state == S_EXEC) begin
        case (cmd)
          8'h01: begin
            o_led_data <= arg;
            o_led_we   <= 1'b1;
          end
          8'h02:   o_mode <= arg[1:0];
          8'h03: begin
            o_led_data <= o_led_data ^ arg;
            o_led_we   <= 1'b1;
          end
          8'h04:   o_err_cnt <= 8'd0;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
